// File: rtl/err_sweep_eval.sv
`default_nettype none
// ============================================================================
// Module   : err_sweep_eval
// Purpose  : Exhaustive error-evaluation harness. Sweeps every input vector
//            0..N_VEC-1 on pi, holds each for SETTLE+1 cycles, samples the
//            exact and approximate circuit responses on the last cycle, and
//            accumulates error metrics on chip.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - begin a sweep (honoured in IDLE or DONE only)
//            pi              - current input vector to both circuits
//            exact_po/appx_po- combinational responses of the two circuits
//            busy / done     - sweep in progress / result valid
//            err_cnt         - number of vectors with differing outputs
//            err_sum         - sum of |exact_po - appx_po|
//            err_max         - maximum |exact_po - appx_po|
//            worst_vec       - first vector reaching err_max
//            hd_sum          - sum of Hamming distances between outputs
// Revision : 1.0 - initial release
// ============================================================================
module err_sweep_eval #(
   parameter int N_IN   = 4,
   parameter int W_OUT  = 3,
   parameter int N_VEC  = 16,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [N_IN-1:0]       pi,
   input  logic [W_OUT-1:0]      exact_po,
   input  logic [W_OUT-1:0]      appx_po,
   output logic                  busy,
   output logic                  done,
   output logic [N_IN:0]         err_cnt,
   output logic [W_OUT+N_IN-1:0] err_sum,
   output logic [W_OUT-1:0]      err_max,
   output logic [N_IN-1:0]       worst_vec,
   output logic [W_OUT+N_IN-1:0] hd_sum
);

   localparam int              SUM_W      = W_OUT + N_IN;
   localparam logic [N_IN-1:0] C_LAST_VEC = N_IN'(N_VEC - 1);
   // SETTLE is limited to 0..7, so a 3-bit counter always suffices
   localparam logic [2:0]      C_SETTLE   = 3'(SETTLE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [N_IN-1:0]   pi_q,        pi_d;
   logic [2:0]        settle_q,    settle_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic [N_IN:0]     err_cnt_q,   err_cnt_d;
   logic [SUM_W-1:0]  err_sum_q,   err_sum_d;
   logic [W_OUT-1:0]  err_max_q,   err_max_d;
   logic [N_IN-1:0]   worst_vec_q, worst_vec_d;
   logic [SUM_W-1:0]  hd_sum_q,    hd_sum_d;

   // Absolute difference at one extra bit so the subtraction cannot wrap
   logic [W_OUT:0]    w_diff;
   logic [W_OUT-1:0]  w_xor;
   logic [SUM_W-1:0]  w_hd;

   always_comb begin
      if (exact_po >= appx_po) begin
         w_diff = {1'b0, exact_po} - {1'b0, appx_po};
      end else begin
         w_diff = {1'b0, appx_po} - {1'b0, exact_po};
      end
      w_xor = exact_po ^ appx_po;
      w_hd  = '0;
      for (int i = 0; i < W_OUT; i++) begin
         w_hd = w_hd + SUM_W'(w_xor[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      pi_d        = pi_q;
      settle_d    = settle_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_cnt_d   = err_cnt_q;
      err_sum_d   = err_sum_q;
      err_max_d   = err_max_q;
      worst_vec_d = worst_vec_q;
      hd_sum_d    = hd_sum_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_SWEEP;
               pi_d        = '0;
               settle_d    = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               err_cnt_d   = '0;
               err_sum_d   = '0;
               err_max_d   = '0;
               worst_vec_d = '0;
               hd_sum_d    = '0;
            end
         end
         ST_SWEEP: begin
            if (settle_q == C_SETTLE) begin
               err_cnt_d = err_cnt_q + (N_IN+1)'(w_diff != '0);
               err_sum_d = err_sum_q + SUM_W'(w_diff);
               hd_sum_d  = hd_sum_q + w_hd;
               // Strictly greater: on ties the earlier vector is kept
               if (w_diff > {1'b0, err_max_q}) begin
                  err_max_d   = w_diff[W_OUT-1:0];
                  worst_vec_d = pi_q;
               end
               if (pi_q == C_LAST_VEC) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  pi_d     = pi_q + 1'b1;
                  settle_d = '0;
               end
            end else begin
               settle_d = settle_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pi_q        <= '0;
         settle_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_cnt_q   <= '0;
         err_sum_q   <= '0;
         err_max_q   <= '0;
         worst_vec_q <= '0;
         hd_sum_q    <= '0;
      end else begin
         state_q     <= state_d;
         pi_q        <= pi_d;
         settle_q    <= settle_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_cnt_q   <= err_cnt_d;
         err_sum_q   <= err_sum_d;
         err_max_q   <= err_max_d;
         worst_vec_q <= worst_vec_d;
         hd_sum_q    <= hd_sum_d;
      end
   end

   assign pi        = pi_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_cnt   = err_cnt_q;
   assign err_sum   = err_sum_q;
   assign err_max   = err_max_q;
   assign worst_vec = worst_vec_q;
   assign hd_sum    = hd_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_err_sweep_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_err_sweep_eval
// Purpose  : Self-checking bench for err_sweep_eval. Drives a default
//            instance and an N_VEC=15/SETTLE=0 instance with modelled
//            exact/approximate circuits and compares the reported metrics
//            with a reference computed directly from the metric definitions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_err_sweep_eval;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   int         mode = 0;
   logic [2:0] rnd_e [16];
   logic [2:0] rnd_a [16];

   logic [3:0] pi, pi2, worst_vec, worst_vec2;
   logic [2:0] exact_po, appx_po, exact2, appx2, err_max, err_max2;
   logic       busy, done, busy2, done2;
   logic [4:0] err_cnt, err_cnt2;
   logic [6:0] err_sum, hd_sum, err_sum2, hd_sum2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // mode 0: appx = exact, 1: appx = exact & 010, 2: appx = 0,
   // 3: random lookup tables for both circuits
   function automatic logic [2:0] exact_val(int m, logic [3:0] v, logic [2:0] r);
      logic [2:0] a, b;
      if (m == 3) return r;
      a = {1'b0, v[1:0]};
      b = {1'b0, v[3:2]};
      return (a >= b) ? a - b : b - a;
   endfunction

   function automatic logic [2:0] appx_val(int m, logic [2:0] e, logic [2:0] r);
      case (m)
         0:       return e;
         1:       return e & 3'b010;
         2:       return 3'b000;
         default: return r;
      endcase
   endfunction

   always_comb begin
      exact_po = exact_val(mode, pi, rnd_e[pi]);
      appx_po  = appx_val(mode, exact_po, rnd_a[pi]);
      exact2   = exact_val(mode, pi2, rnd_e[pi2]);
      appx2    = appx_val(mode, exact2, rnd_a[pi2]);
   end

   err_sweep_eval dut (
      .clk(clk), .rst(rst), .start(start), .pi(pi),
      .exact_po(exact_po), .appx_po(appx_po), .busy(busy), .done(done),
      .err_cnt(err_cnt), .err_sum(err_sum), .err_max(err_max),
      .worst_vec(worst_vec), .hd_sum(hd_sum)
   );

   err_sweep_eval #(.N_IN(4), .W_OUT(3), .N_VEC(15), .SETTLE(0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .pi(pi2),
      .exact_po(exact2), .appx_po(appx2), .busy(busy2), .done(done2),
      .err_cnt(err_cnt2), .err_sum(err_sum2), .err_max(err_max2),
      .worst_vec(worst_vec2), .hd_sum(hd_sum2)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference metrics straight from the definitions, over vectors 0..nvec-1
   task automatic ref_model(input int nvec, output int c, output int s,
                            output int mx, output int w, output int h);
      c = 0; s = 0; mx = 0; w = 0; h = 0;
      for (int v = 0; v < nvec; v++) begin
         int e, a, d;
         e = int'(exact_val(mode, 4'(v), rnd_e[v]));
         a = int'(appx_val(mode, 3'(e), rnd_a[v]));
         d = (e > a) ? e - a : a - e;
         if (d != 0) c++;
         s += d;
         h += $countones(3'(e ^ a));
         if (d > mx) begin
            mx = d;
            w  = v;
         end
      end
   endtask

   task automatic check_metrics(input string tag, input int c, input int s,
                                input int mx, input int w, input int h);
      check({tag, "_err_cnt"},   int'(err_cnt),   c);
      check({tag, "_err_sum"},   int'(err_sum),   s);
      check({tag, "_err_max"},   int'(err_max),   mx);
      check({tag, "_worst_vec"}, int'(worst_vec), w);
      check({tag, "_hd_sum"},    int'(hd_sum),    h);
   endtask

   task automatic check_model(input string tag);
      int c, s, mx, w, h;
      ref_model(16, c, s, mx, w, h);
      check_metrics(tag, c, s, mx, w, h);
   endtask

   // Pulses start, checks the cleared state right after the start edge, then
   // runs to done. poke >= 0 raises start again at that sweep cycle.
   task automatic run_sweep(input string tag, input int poke,
                            output int lat, output int busy_n);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_clr_busy"}, int'(busy), 1);
      check({tag, "_clr_done"}, int'(done), 0);
      check({tag, "_clr_pi"},   int'(pi),   0);
      check({tag, "_clr_sum"},  int'(err_sum) + int'(err_cnt) + int'(err_max)
                                + int'(worst_vec) + int'(hd_sum), 0);
      lat = 0;
      busy_n = 0;
      while (!done && lat < 200) begin
         if (busy) busy_n++;
         start = (lat == poke);
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      check({tag, "_reached_done"}, int'(done), 1);
   endtask

   typedef struct {
      int mode;
      int cnt;
      int sum;
      int mx;
      int worst;
      int hd;
   } vec_t;

   initial begin
      vec_t tbl[3];
      int   lat, busy_n;

      tbl[0] = '{0, 0,  0, 0, 0, 0};
      tbl[1] = '{1, 8,  8, 1, 1, 8};
      tbl[2] = '{2, 12, 20, 3, 3, 14};
      for (int i = 0; i < 16; i++) begin
         rnd_e[i] = '0;
         rnd_a[i] = '0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_pi", int'(pi), 0);
      check("rst_busy_done", int'(busy) + int'(done) + int'(busy2) + int'(done2), 0);
      check_metrics("rst", 0, 0, 0, 0, 0);

      // Fixed circuit pairs with hand-derived results
      for (int t = 0; t < 3; t++) begin
         mode = tbl[t].mode;
         run_sweep($sformatf("tbl%0d", t), -1, lat, busy_n);
         check($sformatf("tbl%0d_latency", t), lat, 32);
         check($sformatf("tbl%0d_busy_cycles", t), busy_n, 32);
         check($sformatf("tbl%0d_busy_low", t), int'(busy), 0);
         check($sformatf("tbl%0d_last_pi", t), int'(pi), 15);
         check_metrics($sformatf("tbl%0d", t), tbl[t].cnt, tbl[t].sum,
                       tbl[t].mx, tbl[t].worst, tbl[t].hd);
      end

      // DONE holds everything stable
      repeat (3) @(posedge clk);
      #1;
      check("hold_done", int'(done), 1);
      check("hold_pi", int'(pi), 15);
      check_metrics("hold", tbl[2].cnt, tbl[2].sum, tbl[2].mx, tbl[2].worst, tbl[2].hd);

      // Restart from DONE reproduces the same result
      run_sweep("rerun", -1, lat, busy_n);
      check("rerun_latency", lat, 32);
      check_metrics("rerun", tbl[2].cnt, tbl[2].sum, tbl[2].mx, tbl[2].worst, tbl[2].hd);

      // start during SWEEP is ignored
      run_sweep("poke", 5, lat, busy_n);
      check("poke_latency", lat, 32);
      check_model("poke");

      // Reset mid-sweep aborts
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midrst_busy_before", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_pi", int'(pi), 0);
      check_metrics("midrst", 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_idle", int'(busy) + int'(done), 0);
      run_sweep("after_rst", -1, lat, busy_n);
      check("after_rst_latency", lat, 32);
      check_model("after_rst");

      // Random circuit pairs
      mode = 3;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) begin
            rnd_e[i] = 3'($urandom_range(0, 7));
            rnd_a[i] = ($urandom_range(0, 2) == 0) ? rnd_e[i] : 3'($urandom_range(0, 7));
         end
         run_sweep($sformatf("rnd%0d", r), -1, lat, busy_n);
         check($sformatf("rnd%0d_latency", r), lat, 32);
         check_model($sformatf("rnd%0d", r));
      end

      // Short instance: N_VEC=15, SETTLE=0, stuck-at-0 approximation
      mode = 2;
      begin
         int c, s, mx, w, h;
         ref_model(15, c, s, mx, w, h);
         @(negedge clk);
         start2 = 1'b1;
         @(posedge clk);
         #1;
         start2 = 1'b0;
         lat = 0;
         while (!done2 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check("n15_reached_done", int'(done2), 1);
         check("n15_latency", lat, 15);
         check("n15_last_pi", int'(pi2), 14);
         check("n15_err_cnt", int'(err_cnt2), c);
         check("n15_err_sum", int'(err_sum2), s);
         check("n15_err_max", int'(err_max2), mx);
         check("n15_worst_vec", int'(worst_vec2), w);
         check("n15_hd_sum", int'(hd_sum2), h);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
